// File: rtl/msi_stimulus_sequencer_if.sv
// rtl/msi_stimulus_sequencer_if.sv - request handshake bus between stimulus sequencer and consumer
//
// Purpose: groups the valid/ready request channel and its payload fields.
// Signals:
//   ReqValid    request fields valid (master -> slave)
//   ReqReady    consumer accepts request (slave -> master)
//   AddressTest request address code
//   WriteOrRead request op (00 Read, 01 Write, 1x reserved)
//   Processor   request processor id
//   DataTest    request data code
interface msi_stimulus_sequencer_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int PROC_W = 2
);
   logic              ReqValid;
   logic              ReqReady;
   logic [ADDR_W-1:0] AddressTest;
   logic [1:0]        WriteOrRead;
   logic [PROC_W-1:0] Processor;
   logic [DATA_W-1:0] DataTest;

   modport master (
      output ReqValid, AddressTest, WriteOrRead, Processor, DataTest,
      input  ReqReady
   );

   modport slave (
      input  ReqValid, AddressTest, WriteOrRead, Processor, DataTest,
      output ReqReady
   );
endinterface

// File: rtl/msi_stimulus_sequencer.sv
// rtl/msi_stimulus_sequencer.sv - loadable scripted request generator for MSI directory benches
//
// Purpose: holds a script of processor requests and issues one per
// valid/ready handshake, with run-time loading, variable length,
// inter-request gaps, loop mode, abort and completion status.
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   Start, Abort      run control (Abort has priority over Start)
//   LoopMode          restart at entry 0 after the last entry
//   NumEntries        script length, sampled on Start (clamped to DEPTH)
//   GapCycles         idle cycles after each handshake, sampled on Start
//   LoadEn..LoadData  table write port, ignored while Busy
//   req               request channel (master side)
//   Busy, Done        run in progress / run completed
//   IssuedCount       handshakes completed since the last Start
module msi_stimulus_sequencer #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int PROC_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Abort,
   input  logic                  LoopMode,
   input  logic [IDX_W:0]        NumEntries,
   input  logic [7:0]            GapCycles,
   input  logic                  LoadEn,
   input  logic [IDX_W-1:0]      LoadIdx,
   input  logic [ADDR_W-1:0]     LoadAddr,
   input  logic [1:0]            LoadOp,
   input  logic [PROC_W-1:0]     LoadProc,
   input  logic [DATA_W-1:0]     LoadData,
   msi_stimulus_sequencer_if.master req,
   output logic                  Busy,
   output logic                  Done,
   output logic [CNT_W-1:0]      IssuedCount
);

   localparam int ENTRY_W = ADDR_W + 2 + PROC_W + DATA_W;
   localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

   state_t             state, state_n;
   logic [IDX_W-1:0]   idx, idx_n;
   logic [IDX_W:0]     len, len_n, len_start;
   logic [7:0]         gap, gap_n, gap_cnt, gap_cnt_n;
   logic [CNT_W-1:0]   cnt_n;
   logic               fire, last, load_we;
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] load_entry, entry_n;
   logic               valid_n, busy_n, done_n;

   // ReqValid is registered as (state == ISSUE), so it doubles as the
   // "currently issuing" qualifier for the handshake.
   assign fire       = req.ReqValid & req.ReqReady;
   assign last       = ({1'b0, idx} == (len - 1'b1));
   assign load_we    = LoadEn & ~Busy;
   assign load_entry = {LoadAddr, LoadOp, LoadProc, LoadData};
   assign len_start  = (NumEntries > DEPTH_L) ? DEPTH_L : NumEntries;

   // Script table: no reset, contents survive Reset.
   always_ff @(posedge Clock) begin
      if (load_we) begin
         mem[LoadIdx] <= load_entry;
      end
   end

   // State and registered outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state           <= S_IDLE;
         idx             <= '0;
         len             <= '0;
         gap             <= '0;
         gap_cnt         <= '0;
         IssuedCount     <= '0;
         Busy            <= 1'b0;
         Done            <= 1'b0;
         req.ReqValid    <= 1'b0;
         req.AddressTest <= '0;
         req.WriteOrRead <= '0;
         req.Processor   <= '0;
         req.DataTest    <= '0;
      end else begin
         state           <= state_n;
         idx             <= idx_n;
         len             <= len_n;
         gap             <= gap_n;
         gap_cnt         <= gap_cnt_n;
         IssuedCount     <= cnt_n;
         Busy            <= busy_n;
         Done            <= done_n;
         req.ReqValid    <= valid_n;
         {req.AddressTest, req.WriteOrRead, req.Processor, req.DataTest} <= entry_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      len_n     = len;
      gap_n     = gap;
      gap_cnt_n = gap_cnt;
      // A handshake on the Abort edge still counts.
      cnt_n     = fire ? IssuedCount + CNT_W'(1) : IssuedCount;
      if (Abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  len_n   = len_start;
                  gap_n   = GapCycles;
                  idx_n   = '0;
                  cnt_n   = '0;
                  state_n = (len_start == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (fire) begin
                  if (last && !LoopMode) begin
                     state_n = S_DONE;
                  end else begin
                     idx_n = last ? '0 : idx + 1'b1;
                     if (gap == 8'd0) begin
                        state_n = S_ISSUE;
                     end else begin
                        state_n   = S_GAP;
                        gap_cnt_n = gap;
                     end
                  end
               end
            end
            S_GAP: begin
               gap_cnt_n = gap_cnt - 8'd1;
               if (gap_cnt == 8'd1) begin
                  state_n = S_ISSUE;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      valid_n = (state_n == S_ISSUE);
      busy_n  = (state_n == S_ISSUE) || (state_n == S_GAP);
      done_n  = (state_n == S_DONE);
      entry_n = '0;
      if (valid_n) begin
         // Forward a same-edge table write so Start+LoadEn sees new data.
         if (load_we && (LoadIdx == idx_n)) begin
            entry_n = load_entry;
         end else begin
            entry_n = mem[idx_n];
         end
      end
   end

endmodule
